// File: rtl/kronos_dmem_responder.sv
// Kronos data-bus responder: word RAM plus machine-timer window (mtime, mtimecmp, msip)
// with a configurable wait-state count before each one-cycle ack.
module kronos_dmem_responder #(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          DEPTH       = 1024,
    parameter logic [31:0] TIMER_BASE  = 32'h8000_0000,
    parameter int          WAIT_STATES = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wr_data,
    input  logic [3:0]  data_mask,
    input  logic        data_wr_en,
    input  logic        data_req,
    output logic [31:0] data_rd_data,
    output logic        data_ack,
    output logic        bus_err,
    output logic        timer_interrupt,
    output logic        software_interrupt,
    output logic [1:0]  dbg_state_o
);

    localparam int          AW        = $clog2(DEPTH);
    localparam logic [32:0] RAM_BYTES = 33'(DEPTH) << 2;
    localparam logic [3:0]  WS_M1     = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    // Handshake: data_req is sampled only in IDLE; data_ack is high for exactly
    // the ACK cycle; once accepted, a transaction always completes unless rst.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_ACK  = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, wdata_q;
    logic [3:0]  mask_q;
    logic        we_q;

    logic [31:0] acc_addr, acc_wdata;
    logic [3:0]  acc_mask;
    logic        acc_we;
    logic [31:0] ram_off, tmr_off;
    logic        ram_hit, tmr_hit;
    logic [AW-1:0] ram_idx;
    logic        commit;

    logic [31:0] mem [DEPTH];
    logic [63:0] mtime_q, mtime_d;
    logic [63:0] mtimecmp_q, mtimecmp_d;
    logic        msip_q, msip_d;
    logic        tirq_q;
    logic [31:0] rd_q, rd_d;
    logic        err_q, err_d;

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                                input logic [31:0] new_w,
                                                input logic [3:0]  m);
        logic [31:0] r;
        r = old_w;
        for (int i = 0; i < 4; i++) begin
            if (m[i]) r[8*i +: 8] = new_w[8*i +: 8];
        end
        return r;
    endfunction

    // With zero wait states the access happens straight from the live inputs.
    always_comb begin
        if (state_q == S_IDLE) begin
            acc_addr  = data_addr & ~32'h3;
            acc_wdata = data_wr_data;
            acc_mask  = data_mask;
            acc_we    = data_wr_en;
        end else begin
            acc_addr  = addr_q;
            acc_wdata = wdata_q;
            acc_mask  = mask_q;
            acc_we    = we_q;
        end
        ram_off = acc_addr - BASE_ADDR;
        tmr_off = acc_addr - TIMER_BASE;
        ram_hit = (acc_addr >= BASE_ADDR) && ({1'b0, ram_off} < RAM_BYTES);
        tmr_hit = (acc_addr >= TIMER_BASE) && (tmr_off < 32'h14);
        ram_idx = ram_off[AW+1:2];
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        commit  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (data_req) begin
                    if (WAIT_STATES == 0) begin
                        state_d = S_ACK;
                        commit  = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = WS_M1;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_ACK;
                    commit  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_ACK:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            mask_q  <= 4'h0;
            we_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (state_q == S_IDLE && data_req) begin
                addr_q  <= acc_addr;
                wdata_q <= acc_wdata;
                mask_q  <= acc_mask;
                we_q    <= acc_we;
            end
        end
    end

    // A store to one mtime half suppresses that cycle's increment entirely.
    always_comb begin
        mtime_d    = mtime_q + 64'd1;
        mtimecmp_d = mtimecmp_q;
        msip_d     = msip_q;
        if (commit && acc_we && tmr_hit) begin
            case (tmr_off[4:2])
                3'd0: mtime_d = {mtime_q[63:32], merge_bytes(mtime_q[31:0], acc_wdata, acc_mask)};
                3'd1: mtime_d = {merge_bytes(mtime_q[63:32], acc_wdata, acc_mask), mtime_q[31:0]};
                3'd2: mtimecmp_d[31:0]  = merge_bytes(mtimecmp_q[31:0], acc_wdata, acc_mask);
                3'd3: mtimecmp_d[63:32] = merge_bytes(mtimecmp_q[63:32], acc_wdata, acc_mask);
                3'd4: if (acc_mask[0]) msip_d = acc_wdata[0];
                default: ;
            endcase
        end
    end

    always_comb begin
        rd_d  = 32'h0;
        err_d = 1'b0;
        if (ram_hit) begin
            if (!acc_we) rd_d = mem[ram_idx];
        end else if (tmr_hit) begin
            if (!acc_we) begin
                case (tmr_off[4:2])
                    3'd0:    rd_d = mtime_q[31:0];
                    3'd1:    rd_d = mtime_q[63:32];
                    3'd2:    rd_d = mtimecmp_q[31:0];
                    3'd3:    rd_d = mtimecmp_q[63:32];
                    3'd4:    rd_d = {31'h0, msip_q};
                    default: rd_d = 32'h0;
                endcase
            end
        end else begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mtime_q    <= 64'h0;
            mtimecmp_q <= 64'hFFFF_FFFF_FFFF_FFFF;
            msip_q     <= 1'b0;
            tirq_q     <= 1'b0;
            rd_q       <= 32'h0;
            err_q      <= 1'b0;
        end else begin
            mtime_q    <= mtime_d;
            mtimecmp_q <= mtimecmp_d;
            msip_q     <= msip_d;
            tirq_q     <= (mtime_q >= mtimecmp_q);
            if (commit) begin
                rd_q  <= rd_d;
                err_q <= err_d;
            end
        end
    end

    // RAM is not reset; rst gates the write so a store racing a reset is lost.
    always_ff @(posedge clk) begin
        if (commit && !rst && acc_we && ram_hit) begin
            for (int i = 0; i < 4; i++) begin
                if (acc_mask[i]) mem[ram_idx][8*i +: 8] <= acc_wdata[8*i +: 8];
            end
        end
    end

    assign data_ack           = (state_q == S_ACK);
    assign bus_err            = data_ack && err_q;
    assign data_rd_data       = rd_q;
    assign timer_interrupt    = tirq_q;
    assign software_interrupt = msip_q;
    assign dbg_state_o        = state_q;

endmodule

// File: doc/kronos_dmem_responder.md
# kronos_dmem_responder

Responder end of the Kronos data interface: accepts load/store requests from the core's execution stage, services them from an internal word-organised RAM or a small machine-timer register window, and returns a one-cycle `data_ack`. It also drives the core's `timer_interrupt` and `software_interrupt` inputs, so a minimal Kronos system needs only this block and an instruction memory.

## Interface
- `BASE_ADDR`, 32'h0000_0000, byte address of RAM word 0.
- `DEPTH`, 1024, RAM size in 32-bit words; power of two, at least 4.
- `TIMER_BASE`, 32'h8000_0000, byte address of the timer register window; must not overlap RAM.
- `WAIT_STATES`, 0, extra cycles inserted before every ack; legal range 0..15.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, asynchronous, active-high.
- `data_addr` in 32: byte address; bits [1:0] are ignored.
- `data_wr_data` in 32: store data, already lane-aligned by the core.
- `data_mask` in 4: byte-lane enables for stores.
- `data_wr_en` in 1: 1 = store, 0 = load.
- `data_req` in 1: request; held stable with addr, data and mask until ack.
- `data_rd_data` out 32: load data; valid in the ack cycle.
- `data_ack` out 1: one-cycle completion pulse.
- `bus_err` out 1: pulses with `data_ack` when the address hits neither RAM nor the timer window.
- `timer_interrupt` out 1: level, mtime >= mtimecmp.
- `software_interrupt` out 1: level, msip bit 0.

## Operation
- FSM states: IDLE, WAIT, ACK.
  - IDLE: if `data_req`, latch decode. Go to ACK when WAIT_STATES = 0; otherwise load cnt = WAIT_STATES-1 and go to WAIT.
  - WAIT: decrement cnt. When cnt = 0, go to ACK.
  - ACK: `data_ack` = 1. Always go to IDLE. `data_req` is ignored in ACK.
- The access is performed on the clock edge that enters ACK. The write is committed and `data_rd_data` is registered on that edge.
- RAM hit: `BASE_ADDR <= addr < BASE_ADDR + 4*DEPTH`. Word index = (addr-BASE_ADDR)[log2(DEPTH)+1:2].
  - Store: for each i with `data_mask[i]` = 1, byte i of the word takes `wr_data[8i+7:8i]`. Other bytes are unchanged.
  - Load: returns the full word. Mask is ignored.
- Timer window offsets from TIMER_BASE:
  - 0x00 mtime[31:0], 0x04 mtime[63:32].
  - 0x08 mtimecmp[31:0], 0x0C mtimecmp[63:32].
  - 0x10 msip; only bit 0 is stored, other bits read 0.
  - Stores honour the byte mask.
  - Offsets 0x14–0x1F and any address outside both regions count as a miss.
- Miss: load returns 32'h0, store is dropped, `bus_err` = 1 in the ack cycle.
- mtime: 64-bit, increments by 1 every cycle and wraps from all-ones to 0.
  - A store to a mtime half replaces that half in that cycle, and there is no increment that cycle.
  - The other half holds its value, with no carry.
- `timer_interrupt` is registered from the compare (mtime >= mtimecmp, unsigned) of the current register values. `software_interrupt` = msip.

## Timing
- Reset values:
  - state IDLE; `data_ack`, `bus_err` = 0; `data_rd_data` = 0.
  - mtime = 0; mtimecmp = 64'hFFFF_FFFF_FFFF_FFFF; msip = 0; `timer_interrupt`, `software_interrupt` = 0.
  - RAM contents are not reset.
- Latency: `data_req` first seen high in cycle t gives `data_ack` in cycle t+1+WAIT_STATES.
- Back-to-back: if `data_req` is still high in cycle after the ack, it is a new request. Minimum spacing is 2+WAIT_STATES cycles per transaction.
- `data_rd_data` holds its value until the next ack, for both loads and stores. Store acks return 32'h0.
- `data_req` dropping while in WAIT does not abort the transaction; the ack is still issued.
- `rst` asserted mid-transaction: return to IDLE immediately. Any uncommitted store is lost, no ack is issued, and timer state is reset.
- `timer_interrupt` lags the mtime/mtimecmp crossing by 1 cycle. `software_interrupt` rises the cycle after the msip store commits.

## Test plan
- WAIT_STATES=0, store 32'hDEAD_BEEF mask 4'hF to BASE_ADDR+8, then load from the same address → first ack at t+1, load ack returns 32'hDEAD_BEEF, `bus_err` = 0 throughout.
- Byte store 32'h0000_AA00 with mask 4'b0010 over the word 32'h1122_3344 → subsequent load returns 32'h1122_AA44.
- WAIT_STATES=3, `data_req` held high continuously for 3 loads → acks in cycles t+4, t+9, t+14, each exactly one cycle wide.
- Load from BASE_ADDR+4*DEPTH and store to TIMER_BASE+0x14 → both acks have `bus_err` = 1, the load returns 0, and RAM/timer state is unchanged.
- Write mtimecmp high = 0 and low = 100 → `timer_interrupt` rises exactly 1 cycle after mtime reaches 100. Write mtime low = 32'hFFFF_FFFF → mtime high is unchanged that cycle, then carries on the next increment.
- Assert `rst` during WAIT of a store → no ack, the target word is unchanged, and all outputs return to reset values.
